// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage sitting between execute (EX) and write-back
//   (WB). Takes one instruction per cycle from EX over a valid/allowin
//   handshake. Loads stall here until the data SRAM returns its response; the
//   addressed byte/half/word is then extracted and sign- or zero-extended.
//   If WB is not ready when the load data arrives, the data is parked in a
//   local buffer so the SRAM response (a one-cycle pulse) is not lost.
//
// Ports
//   clk               clock
//   resetn            asynchronous active-low reset
//   ws_allowin        WB can accept an instruction this cycle
//   ms_allowin        MEM can accept an instruction from EX this cycle
//   es_to_ms_valid    EX presents an instruction
//   es_to_ms_bus      EX bundle {res_from_mem, load_op, gr_we, dest, alu_result, pc}
//   ms_to_ws_valid    MEM presents a completed instruction to WB
//   ms_to_ws_bus      WB bundle {gr_we, dest, final_result, pc}
//   ms_to_ds_bus      forwarding/interlock bundle {fwd_we, load_pending, dest, result}
//   data_sram_data_ok load response valid (single-cycle pulse)
//   data_sram_rdata   load response data
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int ES_TO_MS_WD = 74,
  parameter int MS_TO_WS_WD = 70,
  parameter int MS_TO_DS_WD = 39
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ws_allowin,
  output logic                   ms_allowin,
  input  logic                   es_to_ms_valid,
  input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  output logic                   ms_to_ws_valid,
  output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_WD-1:0] ms_to_ds_bus,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_t;

  // load_op encoding
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  // Byte/half/word extraction from the returned SRAM word. Codes outside the
  // defined sub-word loads fall back to a full-word load.
  function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                               input logic [1:0]  a,
                                               input logic [31:0] word);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    shifted = word >> {a, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = a[1] ? word[31:16] : word[15:0];
    case (op)
      LD_B:    load_extract = {{24{byte_s[7]}}, byte_s};
      LD_H:    load_extract = {{16{half_s[15]}}, half_s};
      LD_BU:   load_extract = {24'd0, byte_s};
      LD_HU:   load_extract = {16'd0, half_s};
      default: load_extract = word;
    endcase
  endfunction

  logic                   vld_p0;
  logic [ES_TO_MS_WD-1:0] bus_p0;
  logic [31:0]            rdata_buf_p0;
  state_t                 state_q;
  state_t                 state_d;

  logic                   res_from_mem_p0;
  logic [2:0]             load_op_p0;
  logic                   gr_we_p0;
  logic [4:0]             dest_p0;
  logic [31:0]            alu_result_p0;
  logic [31:0]            pc_p0;
  logic [31:0]            load_word_p0;
  logic [31:0]            final_result_p0;
  logic                   ms_ready_go;
  logic                   es_is_load;

  assign {res_from_mem_p0, load_op_p0, gr_we_p0, dest_p0, alu_result_p0, pc_p0} = bus_p0;
  assign es_is_load = es_to_ms_bus[ES_TO_MS_WD-1];

  assign ms_ready_go    = !res_from_mem_p0 || (state_q == HELD) ||
                          ((state_q == WAIT) && data_sram_data_ok);
  assign ms_allowin     = !vld_p0 || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = vld_p0 && ms_ready_go;

  // Whenever MEM can accept, the next state depends only on what EX hands
  // over (a load starts waiting, anything else needs no SRAM tracking). The
  // only blocked transition is load data arriving while WB is stalled.
  always_comb begin
    state_d = state_q;
    if (ms_allowin) begin
      state_d = (es_to_ms_valid && es_is_load) ? WAIT : IDLE;
    end else if ((state_q == WAIT) && data_sram_data_ok) begin
      state_d = HELD;
    end
  end

  // ---- EX -> MEM boundary: control ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0  <= 1'b0;
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      if (ms_allowin) begin
        vld_p0 <= es_to_ms_valid;
      end
    end
  end

  // ---- EX -> MEM boundary: data ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_p0       <= '0;
      rdata_buf_p0 <= '0;
    end else begin
      if (es_to_ms_valid && ms_allowin) begin
        bus_p0 <= es_to_ms_bus;
      end
      if ((state_q == WAIT) && data_sram_data_ok && !ws_allowin) begin
        rdata_buf_p0 <= data_sram_rdata;
      end
    end
  end

  assign load_word_p0    = (state_q == HELD) ? rdata_buf_p0 : data_sram_rdata;
  assign final_result_p0 = res_from_mem_p0 ?
                           load_extract(load_op_p0, alu_result_p0[1:0], load_word_p0) :
                           alu_result_p0;

  assign ms_to_ws_bus = {gr_we_p0, dest_p0, final_result_p0, pc_p0};
  assign ms_to_ds_bus = {vld_p0 && gr_we_p0,
                         vld_p0 && res_from_mem_p0 && !ms_ready_go,
                         dest_p0,
                         final_result_p0};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int tests;
  int failed;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        res;
    logic [2:0]  op;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [73:0] mk(input logic res, input logic [2:0] op,
                                     input logic gr_we, input logic [4:0] dest,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {res, op, gr_we, dest, alu, pc};
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    resetn = 1'b0;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;

    //                 res op    dest   alu           pc            rdata         expected
    vecs[0]  = '{1'b1, 3'd4, 5'd1,  32'h0000_0002, 32'h1c00_1000, 32'h8001_F00F, 32'h0000_8001};
    vecs[1]  = '{1'b1, 3'd2, 5'd2,  32'h0000_0000, 32'h1c00_1004, 32'h8001_F00F, 32'hFFFF_F00F};
    vecs[2]  = '{1'b1, 3'd1, 5'd3,  32'h8000_0003, 32'h1c00_1008, 32'h80FF_1234, 32'hFFFF_FF80};
    vecs[3]  = '{1'b1, 3'd3, 5'd4,  32'h0000_0001, 32'h1c00_100c, 32'h80FF_1234, 32'h0000_0012};
    vecs[4]  = '{1'b1, 3'd1, 5'd5,  32'h0000_0002, 32'h1c00_1010, 32'h80FF_1234, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b1, 3'd3, 5'd6,  32'h0000_0002, 32'h1c00_1014, 32'h80FF_1234, 32'h0000_00FF};
    vecs[6]  = '{1'b1, 3'd2, 5'd7,  32'h0000_0002, 32'h1c00_1018, 32'h80FF_1234, 32'hFFFF_80FF};
    vecs[7]  = '{1'b1, 3'd4, 5'd8,  32'h0000_0000, 32'h1c00_101c, 32'h80FF_1234, 32'h0000_1234};
    vecs[8]  = '{1'b1, 3'd0, 5'd9,  32'h0000_0000, 32'h1c00_1020, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 3'd5, 5'd10, 32'h0000_0001, 32'h1c00_1024, 32'h1234_5678, 32'h1234_5678};
    vecs[10] = '{1'b1, 3'd7, 5'd11, 32'h0000_0003, 32'h1c00_1028, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
    vecs[11] = '{1'b0, 3'd1, 5'd12, 32'hCAFE_BABE, 32'h1c00_102c, 32'h1111_1111, 32'hCAFE_BABE};
    vecs[12] = '{1'b1, 3'd1, 5'd13, 32'h0000_0000, 32'h1c00_1030, 32'h8001_F00F, 32'h0000_000F};

    // Reset state
    tick();
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_ws_valid", ms_to_ws_valid, 0);
    chk("rst_ds_bus", ms_to_ds_bus, 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rel_allowin", ms_allowin, 1);
    chk("rel_ws_valid", ms_to_ws_valid, 0);
    chk("rel_ds_bus", ms_to_ds_bus, 0);

    // Three back-to-back ALU ops
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 0, 1, 5, 32'h11, 32'h1c00_0000);
    tick();
    es_to_ms_bus = mk(0, 0, 1, 5, 32'h22, 32'h1c00_0004);
    #1;
    chk("alu0_valid", ms_to_ws_valid, 1);
    chk("alu0_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h11, 32'h1c00_0000});
    chk("alu0_allowin", ms_allowin, 1);
    tick();
    es_to_ms_bus = mk(0, 0, 1, 5, 32'h33, 32'h1c00_0008);
    #1;
    chk("alu1_valid", ms_to_ws_valid, 1);
    chk("alu1_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h22, 32'h1c00_0004});
    chk("alu1_fwd", ms_to_ds_bus, {1'b1, 1'b0, 5'd5, 32'h22});
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("alu2_valid", ms_to_ws_valid, 1);
    chk("alu2_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h33, 32'h1c00_0008});
    tick();
    chk("alu_drain", ms_to_ws_valid, 0);

    // Table: each instruction enters, data_ok arrives the very next cycle
    for (int i = 0; i < 13; i++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk(vecs[i].res, vecs[i].op, 1, vecs[i].dest, vecs[i].alu, vecs[i].pc);
      tick();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_valid", i), ms_to_ws_valid, 1);
      chk($sformatf("vec%0d_bus", i), ms_to_ws_bus, {1'b1, vecs[i].dest, vecs[i].exp, vecs[i].pc});
      tick();
      data_sram_data_ok = 1'b0;
    end

    // ld.b with data_ok two cycles after entry
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1, 3'd1, 1, 7, 32'h8000_0003, 32'h1c00_0100);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("ldb_pending", ms_to_ds_bus[38:37], 2'b11);
    chk("ldb_allowin", ms_allowin, 0);
    chk("ldb_wait_valid", ms_to_ws_valid, 0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80FF_1234;
    #1;
    chk("ldb_valid", ms_to_ws_valid, 1);
    chk("ldb_result", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    chk("ldb_pending_clr", ms_to_ds_bus[37], 0);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    chk("ldb_drain", ms_to_ws_valid, 0);

    // ld.w held while WB stalls for three cycles
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1, 3'd0, 1, 9, 32'h0000_0100, 32'h1c00_0200);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("held1_valid", ms_to_ws_valid, 1);
    chk("held1_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
    chk("held1_allowin", ms_allowin, 0);
    tick();
    data_sram_rdata = 32'h0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 0, 1, 3, 32'h55, 32'h1c00_0204);
    #1;
    chk("held2_valid", ms_to_ws_valid, 1);
    chk("held2_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
    chk("held2_allowin", ms_allowin, 0);
    chk("held2_pending", ms_to_ds_bus[37], 0);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    chk("held3_valid", ms_to_ws_valid, 1);
    chk("held3_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
    tick();
    ws_allowin = 1'b1;
    #1;
    chk("held4_valid", ms_to_ws_valid, 1);
    chk("held4_bus", ms_to_ws_bus, {1'b1, 5'd9, 32'hDEAD_BEEF, 32'h1c00_0200});
    chk("held4_allowin", ms_allowin, 1);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("after_held_valid", ms_to_ws_valid, 1);
    chk("after_held_bus", ms_to_ws_bus, {1'b1, 5'd3, 32'h55, 32'h1c00_0204});
    tick();
    chk("after_held_drain", ms_to_ws_valid, 0);

    // Reset during WAIT, then a spurious data_ok
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1, 3'd0, 1, 4, 32'h0000_0200, 32'h1c00_0300);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("rw_pending", ms_to_ds_bus[37], 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rw_allowin", ms_allowin, 1);
    chk("rw_valid", ms_to_ws_valid, 0);
    chk("rw_ds_bus", ms_to_ds_bus, 0);
    #1;
    resetn = 1'b1;
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h7777_7777;
    #1;
    chk("spur_valid", ms_to_ws_valid, 0);
    chk("spur_ds_bus", ms_to_ds_bus, 0);
    chk("spur_allowin", ms_allowin, 1);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    chk("spur_after_valid", ms_to_ws_valid, 0);
    // A fresh load must still wait for its own response
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1, 3'd0, 1, 6, 32'h0000_0300, 32'h1c00_0400);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("post_rst_pending", ms_to_ds_bus[37], 1);
    chk("post_rst_wait_valid", ms_to_ws_valid, 0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0102_0304;
    #1;
    chk("post_rst_bus", ms_to_ws_bus, {1'b1, 5'd6, 32'h0102_0304, 32'h1c00_0400});
    chk("post_rst_valid", ms_to_ws_valid, 1);
    tick();
    data_sram_data_ok = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage.
- Accepts one instruction per cycle from EX over the valid/allowin handshake.
- For loads, waits for the data-SRAM response, then extracts and sign/zero-extends the addressed byte, half or word.
- Drives the result bundle {gr_we, dest, final_result, pc} to WB using the same handshake that WB consumes, and drives a forwarding/stall bus to decode.

Parameters:
- ES_TO_MS_WD, 74, width of es_to_ms_bus = {res_from_mem[73], load_op[72:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- MS_TO_WS_WD, 70, width of ms_to_ws_bus = {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- MS_TO_DS_WD, 39, width of ms_to_ds_bus = {fwd_we[38], load_pending[37], dest[36:32], result[31:0]}

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- ws_allowin  input  1  WB can accept
- ms_allowin  output  1  MEM can accept from EX
- es_to_ms_valid  input  1  EX presents an instruction
- es_to_ms_bus  input  ES_TO_MS_WD  EX bundle
- ms_to_ws_valid  output  1  MEM presents an instruction to WB
- ms_to_ws_bus  output  MS_TO_WS_WD  WB bundle
- ms_to_ds_bus  output  MS_TO_DS_WD  forwarding/interlock info
- data_sram_data_ok  input  1  load response valid (one-cycle pulse)
- data_sram_rdata  input  32  load response data

Behaviour:
- Handshake:
  - ms_ready_go = !res_from_mem || state==HELD || (state==WAIT && data_sram_data_ok).
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - On es_to_ms_valid && ms_allowin, the bundle register captures es_to_ms_bus. When ms_allowin is high, ms_valid <= es_to_ms_valid.
- State machine (states IDLE, WAIT, HELD):
  - IDLE -> WAIT: a load (res_from_mem=1) is accepted.
  - WAIT -> IDLE: data_ok arrives and ws_allowin=1. The instruction leaves the same cycle, and if a new load is accepted that cycle the state goes directly to WAIT.
  - WAIT -> HELD: data_ok arrives and ws_allowin=0. data_sram_rdata is captured into rdata_buf.
  - HELD -> IDLE (or WAIT): when ws_allowin=1.
  - data_ok is ignored in IDLE and HELD (no state change, buffer not overwritten).
  - Exactly one outstanding load; EX issues the next load request only after its own handshake with MEM.
- Load extraction:
  - Source word = rdata_buf in HELD, else data_sram_rdata.
  - a = alu_result[1:0]; load_op encoding: 0 ld.w, 1 ld.b, 2 ld.h, 3 ld.bu, 4 ld.hu; 5–7 behave as ld.w.
  - Byte = word[8a+7:8a]; half = word[16a[1]+15:16a[1]].
  - .b/.h sign-extend; .bu/.hu zero-extend.
  - final_result = extracted value for loads, alu_result otherwise.
- Forwarding bus:
  - fwd_we = ms_valid && gr_we.
  - load_pending = ms_valid && res_from_mem && !ms_ready_go.
  - dest = captured dest; result = final_result (don't-care while load_pending).
- Reset (async, resetn=0): ms_valid=0, state=IDLE, bundle register=0, rdata_buf=0. Consequently ms_to_ws_valid=0, ms_allowin=1, ms_to_ds_bus=0.
- Reset mid-WAIT or mid-HELD discards the instruction; a data_ok arriving after release is ignored.
- Back-to-back non-loads: 1-cycle latency, full throughput.
- Loads: a load whose data_ok arrives the cycle after entry is presented to WB that cycle.

Test Plan:
- Reset release, no stimulus -> ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_bus=0.
- Three back-to-back ALU ops (pc 0x1c000000/04/08, dest 5, alu_result 0x11/0x22/0x33), ws_allowin=1 -> each appears on ms_to_ws_bus exactly one cycle after acceptance, gr_we=1, in order, no bubbles.
- ld.b, alu_result=0x80000003, data_ok 2 cycles after entry with rdata=0x80FF_1234 -> load_pending=1 and ms_allowin=0 while waiting; final_result=0xFFFFFF80.
- Sweep ld.hu at a=2 and ld.h at a=0 on rdata=0x8001_F00F:
  - ld.hu at a=2 -> 0x00008001.
  - ld.h at a=0 -> 0xFFFFF00F.
- ld.w, data_ok=1 with rdata=0xDEADBEEF while ws_allowin=0 for 3 cycles, with rdata changed to 0 afterwards -> state HELD, ms_to_ws_valid=1 held, final_result stays 0xDEADBEEF, and the instruction is handed to WB in the first ws_allowin=1 cycle.
- Assert resetn=0 during WAIT, release, then pulse a spurious data_ok -> ms_valid=0, state IDLE, no ms_to_ws_valid pulse.
